// File: rtl/fetch_seq_ctrl.sv
// fetch_seq_ctrl
// Program-counter owner for the single-cycle core. Each cycle it picks the
// next fetch address from sequential increment, conditional branch, absolute
// jump, stall hold or halt. It buffers one redirect while instruction memory
// is busy, and pulses flush to decode whenever a redirect is applied.
//
// Ports:
//   clk        system clock, rising edge
//   rst        synchronous active-high reset
//   hlt        halt request from decode
//   stall      hazard stall, hold the PC this cycle
//   br_taken   conditional branch resolved taken
//   br_off     signed word offset, relative to iaddr+1
//   jmp        absolute redirect request (wins over br_taken)
//   jmp_tgt    absolute jump target
//   imem_rdy   instruction memory accepted iaddr and returned data
//   iaddr      current fetch address (registered)
//   pc_plus1   iaddr+1 (combinational)
//   fetch_vld  instruction at iaddr is valid this cycle
//   flush      registered one-cycle pulse, kill the instruction in decode
//   halted     core is halted
//
// State  | meaning
// -------+----------------------------------------------------------
// RUN    | normal fetch; fetch_vld follows imem_rdy
// WAIT   | memory busy; hold iaddr, collect the newest redirect
// HALT   | PC frozen until reset
module fetch_seq_ctrl #(
    parameter int AW    = 16,
    parameter int OFF_W = 9
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             hlt,
    input  logic             stall,
    input  logic             br_taken,
    input  logic [OFF_W-1:0] br_off,
    input  logic             jmp,
    input  logic [AW-1:0]    jmp_tgt,
    input  logic             imem_rdy,
    output logic [AW-1:0]    iaddr,
    output logic [AW-1:0]    pc_plus1,
    output logic             fetch_vld,
    output logic             flush,
    output logic             halted
);

    typedef enum logic [1:0] {
        ST_RUN  = 2'd0,
        ST_WAIT = 2'd1,
        ST_HALT = 2'd2
    } state_t;

    state_t        state, state_nxt;
    logic [AW-1:0] iaddr_nxt;
    logic          pend_vld, pend_vld_nxt;
    logic [AW-1:0] pend_tgt, pend_tgt_nxt;
    logic          flush_nxt;
    logic          redirect;
    logic [AW-1:0] off_ext;
    logic [AW-1:0] tgt;

    assign pc_plus1  = iaddr + 1'b1;
    assign off_ext   = {{(AW-OFF_W){br_off[OFF_W-1]}}, br_off};
    assign redirect  = jmp | br_taken;
    assign tgt       = jmp ? jmp_tgt : (pc_plus1 + off_ext);
    assign fetch_vld = (state == ST_RUN) && imem_rdy;
    assign halted    = (state == ST_HALT);

    always_comb begin
        state_nxt    = state;
        iaddr_nxt    = iaddr;
        pend_vld_nxt = pend_vld;
        pend_tgt_nxt = pend_tgt;
        flush_nxt    = 1'b0;
        case (state)
            ST_RUN: begin
                if (redirect && imem_rdy) begin
                    iaddr_nxt = tgt;
                    flush_nxt = 1'b1;
                end else if (redirect) begin
                    pend_tgt_nxt = tgt;
                    pend_vld_nxt = 1'b1;
                    state_nxt    = ST_WAIT;
                end else if (!imem_rdy) begin
                    state_nxt = ST_WAIT;
                end else if (stall) begin
                    // hold; hlt is deliberately not looked at while stalled
                    iaddr_nxt = iaddr;
                end else if (hlt) begin
                    state_nxt = ST_HALT;
                end else begin
                    iaddr_nxt = pc_plus1;
                end
            end
            ST_WAIT: begin
                if (imem_rdy) begin
                    state_nxt    = ST_RUN;
                    pend_vld_nxt = 1'b0;
                    // a redirect arriving on the release cycle is the newest one
                    if (redirect) begin
                        iaddr_nxt = tgt;
                        flush_nxt = 1'b1;
                    end else if (pend_vld) begin
                        iaddr_nxt = pend_tgt;
                        flush_nxt = 1'b1;
                    end
                end else if (redirect) begin
                    pend_tgt_nxt = tgt;
                    pend_vld_nxt = 1'b1;
                end
            end
            ST_HALT: begin
                state_nxt = ST_HALT;
            end
            default: begin
                state_nxt = ST_RUN;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_RUN;
            iaddr    <= '0;
            pend_vld <= 1'b0;
            pend_tgt <= '0;
            flush    <= 1'b0;
        end else begin
            state    <= state_nxt;
            iaddr    <= iaddr_nxt;
            pend_vld <= pend_vld_nxt;
            pend_tgt <= pend_tgt_nxt;
            flush    <= flush_nxt;
        end
    end

endmodule

// File: tb/tb_fetch_seq_ctrl.sv
// tb_fetch_seq_ctrl
// Directed bench for fetch_seq_ctrl. Expected post-edge outputs are queued when
// each cycle's stimulus is driven and popped after the clock edge for checking.
module tb_fetch_seq_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        hlt;
    logic        stall;
    logic        br_taken;
    logic [8:0]  br_off;
    logic        jmp;
    logic [15:0] jmp_tgt;
    logic        imem_rdy;
    logic [15:0] iaddr;
    logic [15:0] pc_plus1;
    logic        fetch_vld;
    logic        flush;
    logic        halted;

    int n_checks = 0;
    int n_errors = 0;

    typedef struct {
        string       tag;
        logic [15:0] iaddr;
        logic        flush;
        logic        halted;
    } exp_t;

    exp_t sb[$];

    fetch_seq_ctrl #(.AW(16), .OFF_W(9)) dut (
        .clk       (clk),
        .rst       (rst),
        .hlt       (hlt),
        .stall     (stall),
        .br_taken  (br_taken),
        .br_off    (br_off),
        .jmp       (jmp),
        .jmp_tgt   (jmp_tgt),
        .imem_rdy  (imem_rdy),
        .iaddr     (iaddr),
        .pc_plus1  (pc_plus1),
        .fetch_vld (fetch_vld),
        .flush     (flush),
        .halted    (halted)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_checks++;
        assert (obs === exp_v) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
        end
    endtask

    // Queue the expected registered outputs, clock once, then pop and compare.
    task automatic edge_expect(input string tag, input logic [15:0] a,
                               input logic f, input logic h);
        exp_t e;
        e.tag = tag; e.iaddr = a; e.flush = f; e.halted = h;
        sb.push_back(e);
        @(posedge clk);
        #1;
        e = sb.pop_front();
        check({e.tag, ".iaddr"},  {16'h0, iaddr},  {16'h0, e.iaddr});
        check({e.tag, ".flush"},  {31'h0, flush},  {31'h0, e.flush});
        check({e.tag, ".halted"}, {31'h0, halted}, {31'h0, e.halted});
    endtask

    task automatic idle();
        hlt = 0; stall = 0; br_taken = 0; br_off = '0; jmp = 0; jmp_tgt = '0; imem_rdy = 1;
    endtask

    task automatic jump_to(input string tag, input logic [15:0] t);
        idle();
        jmp = 1; jmp_tgt = t;
        edge_expect(tag, t, 1'b1, 1'b0);
        idle();
    endtask

    initial begin
        idle();
        rst = 1;
        @(negedge clk);
        edge_expect("reset", 16'h0000, 1'b0, 1'b0);
        check("reset.fetch_vld", {31'h0, fetch_vld}, 32'h1);
        check("reset.pc_plus1", {16'h0, pc_plus1}, 32'h1);
        rst = 0;

        // 1: sequential fetch
        for (int i = 1; i <= 5; i++) begin
            check("seq.fetch_vld", {31'h0, fetch_vld}, 32'h1);
            edge_expect("seq", 16'(i), 1'b0, 1'b0);
        end

        // 2: branches, back-to-back with the setup jump
        jump_to("br_setup1", 16'h0010);
        br_taken = 1; br_off = 9'h1FD;
        edge_expect("br_neg", 16'h000E, 1'b1, 1'b0);
        idle();
        edge_expect("br_neg_after", 16'h000F, 1'b0, 1'b0);
        jump_to("br_setup2", 16'h0010);
        br_taken = 1; br_off = 9'h004;
        edge_expect("br_pos", 16'h0015, 1'b1, 1'b0);
        idle();
        edge_expect("br_pos_after", 16'h0016, 1'b0, 1'b0);

        // 3: jump beats branch, stall and halt in the same cycle
        jump_to("jmp_setup", 16'h0020);
        jmp = 1; jmp_tgt = 16'h1234; br_taken = 1; br_off = 9'h005; hlt = 1; stall = 1;
        edge_expect("jmp_prio", 16'h1234, 1'b1, 1'b0);
        idle();
        edge_expect("jmp_prio_after", 16'h1235, 1'b0, 1'b0);

        // 4: memory busy, newest redirect wins
        jump_to("wait_setup", 16'h0040);
        imem_rdy = 0; jmp = 1; jmp_tgt = 16'h0100;
        #1 check("wait1.fetch_vld", {31'h0, fetch_vld}, 32'h0);
        edge_expect("wait1", 16'h0040, 1'b0, 1'b0);
        jmp_tgt = 16'h0200;
        #1 check("wait2.fetch_vld", {31'h0, fetch_vld}, 32'h0);
        edge_expect("wait2", 16'h0040, 1'b0, 1'b0);
        jmp = 0; jmp_tgt = '0;
        #1 check("wait3.fetch_vld", {31'h0, fetch_vld}, 32'h0);
        edge_expect("wait3", 16'h0040, 1'b0, 1'b0);
        imem_rdy = 1;
        #1 check("wait_rel.fetch_vld", {31'h0, fetch_vld}, 32'h0);
        edge_expect("wait_rel", 16'h0200, 1'b1, 1'b0);
        check("wait_after.fetch_vld", {31'h0, fetch_vld}, 32'h1);
        edge_expect("wait_after", 16'h0201, 1'b0, 1'b0);
        // busy without redirect: same address refetched; stall ignored in WAIT
        imem_rdy = 0;
        edge_expect("refetch_busy", 16'h0201, 1'b0, 1'b0);
        imem_rdy = 1; stall = 1;
        edge_expect("refetch_rel", 16'h0201, 1'b0, 1'b0);
        stall = 0;
        edge_expect("refetch_next", 16'h0202, 1'b0, 1'b0);

        // 5: halt, inputs ignored, reset exits
        jump_to("halt_setup", 16'h0007);
        hlt = 1;
        edge_expect("halt_enter", 16'h0007, 1'b0, 1'b1);
        for (int i = 0; i < 3; i++) begin
            hlt = 0; jmp = i[0]; jmp_tgt = 16'h0055; br_taken = 1; br_off = 9'h010;
            imem_rdy = ~i[0];
            #1 check("halt_hold.fetch_vld", {31'h0, fetch_vld}, 32'h0);
            edge_expect("halt_hold", 16'h0007, 1'b0, 1'b1);
        end
        idle();
        rst = 1;
        edge_expect("halt_reset", 16'h0000, 1'b0, 1'b0);
        rst = 0;
        edge_expect("halt_reset_run", 16'h0001, 1'b0, 1'b0);

        // 6: wrap-around and stall masking halt
        jump_to("wrap_setup", 16'hFFFF);
        check("wrap.pc_plus1", {16'h0, pc_plus1}, 32'h0);
        edge_expect("wrap", 16'h0000, 1'b0, 1'b0);
        stall = 1; hlt = 1;
        edge_expect("stall_hlt1", 16'h0000, 1'b0, 1'b0);
        edge_expect("stall_hlt2", 16'h0000, 1'b0, 1'b0);
        check("stall_hlt.fetch_vld", {31'h0, fetch_vld}, 32'h1);
        stall = 0;
        edge_expect("hlt_after_stall", 16'h0000, 1'b0, 1'b1);
        // negative branch wrapping below zero
        idle();
        rst = 1;
        edge_expect("wrap_br_reset", 16'h0000, 1'b0, 1'b0);
        rst = 0; br_taken = 1; br_off = 9'h1FC;
        edge_expect("wrap_br", 16'hFFFD, 1'b1, 1'b0);
        idle();

        check("sb_empty", sb.size(), 32'h0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
